// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: branch funct3 codes, datapath width,
// reset PC and the PC sequencer state encoding.
package riscv_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_redirect_unit_target_calc.sv
// pc_target_calc: picks the redirect base (jalr uses rs1, everything else the EX pc),
// adds the immediate modulo 2^XLEN and flags targets that are not word aligned.
module pc_target_calc #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            i_beq,
    input  logic            i_bne,
    input  logic            i_bge,
    input  logic            i_blt,
    input  logic            i_jal,
    input  logic            i_jalr,
    input  logic [XLEN-1:0] i_ex_pc,
    input  logic [XLEN-1:0] i_ex_imm,
    input  logic [XLEN-1:0] i_ex_rs1,
    output logic            o_any_taken,
    output logic [XLEN-1:0] o_target,
    output logic            o_misalign
);

    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_sum;

    // jal and conditional branches share the pc-relative form, so only jalr needs priority
    always_comb begin
        w_base      = i_jalr ? i_ex_rs1 : i_ex_pc;
        w_sum       = w_base + i_ex_imm;
        o_target    = i_jalr ? {w_sum[XLEN-1:1], 1'b0} : w_sum;
        o_any_taken = i_beq | i_bne | i_bge | i_blt | i_jal | i_jalr;
        o_misalign  = o_target[1];
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// PC sequencer: owns the fetch PC, applies EX-stage branch/jump redirects and flushes
// wrong-path IF/ID and ID/EX. Optional counters under BRANCH_STATS_EN.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC,
    parameter int          XLEN     = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            ex_valid,
    input  logic            beq,
    input  logic            bne,
    input  logic            bge,
    input  logic            blt,
    input  logic            jal,
    input  logic            jalr,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fetch_en,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic            misalign
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_taken,
    output logic [31:0]     stat_redirect_cycles
`endif
);

    import riscv_pkg::*;

    pc_state_t       r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic [XLEN-1:0] w_target;
    logic            w_any_taken, w_tgt_misalign;
    logic            w_taken, w_redirect, w_flush;

    pc_target_calc #(.XLEN(XLEN)) u_target (
        .i_beq       (beq),
        .i_bne       (bne),
        .i_bge       (bge),
        .i_blt       (blt),
        .i_jal       (jal),
        .i_jalr      (jalr),
        .i_ex_pc     (ex_pc),
        .i_ex_imm    (ex_imm),
        .i_ex_rs1    (ex_rs1),
        .o_any_taken (w_any_taken),
        .o_target    (w_target),
        .o_misalign  (w_tgt_misalign)
    );

    // EX holds a bubble during REDIRECT and nothing is in flight during BOOT
    assign w_taken    = ex_valid & w_any_taken & (r_state == RUN);
    assign w_redirect = w_taken & ~w_tgt_misalign;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        fetch_en    = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            BOOT: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                fetch_en = 1'b1;
                if (w_redirect) begin
                    // redirect wins over a concurrent stall
                    w_flush     = 1'b1;
                    w_pc_nxt    = w_target;
                    w_state_nxt = REDIRECT;
                end else if (!stall) begin
                    w_pc_nxt = r_pc + XLEN'(4);
                end
            end
            REDIRECT: begin
                fetch_en    = 1'b1;
                w_state_nxt = RUN;
                if (!stall) w_pc_nxt = r_pc + XLEN'(4);
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= BOOT;
            r_pc    <= XLEN'(RESET_PC);
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    assign pc         = r_pc;
    assign pc_plus4   = r_pc + XLEN'(4);
    assign flush_ifid = w_flush;
    assign flush_idex = w_flush;
    assign misalign   = w_taken & w_tgt_misalign;

`ifdef BRANCH_STATS_EN
    logic [31:0] r_stat_taken, r_stat_redir;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_taken <= '0;
            r_stat_redir <= '0;
        end else begin
            if (w_redirect && r_stat_taken != 32'hFFFF_FFFF)
                r_stat_taken <= r_stat_taken + 32'd1;
            if (r_state == REDIRECT && r_stat_redir != 32'hFFFF_FFFF)
                r_stat_redir <= r_stat_redir + 32'd1;
        end
    end

    assign stat_taken           = r_stat_taken;
    assign stat_redirect_cycles = r_stat_redir;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: reset/boot, redirects, priority, stall,
// misaligned targets, reset during redirect and PC wrap.
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        reset, stall, ex_valid;
    logic        beq, bne, bge, blt, jal, jalr;
    logic [31:0] ex_pc, ex_imm, ex_rs1;
    logic [31:0] pc, pc_plus4;
    logic        fetch_en, flush_ifid, flush_idex, misalign;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_taken, stat_redirect_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_redirect_unit dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .ex_valid   (ex_valid),
        .beq        (beq),
        .bne        (bne),
        .bge        (bge),
        .blt        (blt),
        .jal        (jal),
        .jalr       (jalr),
        .ex_pc      (ex_pc),
        .ex_imm     (ex_imm),
        .ex_rs1     (ex_rs1),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .fetch_en   (fetch_en),
        .flush_ifid (flush_ifid),
        .flush_idex (flush_idex),
        .misalign   (misalign)
`ifdef BRANCH_STATS_EN
        ,
        .stat_taken           (stat_taken),
        .stat_redirect_cycles (stat_redirect_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one edge, then let inputs settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 0; beq = 0; bne = 0; bge = 0; blt = 0; jal = 0; jalr = 0;
        ex_pc = '0; ex_imm = '0; ex_rs1 = '0;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        reset = 1; stall = 0;
        idle();
        // 1: reset, boot, sequential fetch
        repeat (3) tick();
        reset = 0; settle();
        chk("boot_pc", pc, 32'h0);
        chk("boot_fetch_en", {31'd0, fetch_en}, 32'd0);
        chk("boot_flush", {30'd0, flush_ifid, flush_idex}, 32'd0);
        chk("boot_misalign", {31'd0, misalign}, 32'd0);
        tick(); settle();
        chk("run_pc0", pc, 32'h0);
        chk("run_fetch_en", {31'd0, fetch_en}, 32'd1);
        tick(); settle(); chk("run_pc4", pc, 32'h4);
        chk("run_pc_plus4", pc_plus4, 32'h8);
        tick(); settle(); chk("run_pc8", pc, 32'h8);
        tick(); settle(); chk("run_pcC", pc, 32'hC);

        // 2: beq backward
        ex_valid = 1; beq = 1; ex_pc = 32'h40; ex_imm = 32'hFFFF_FFF0; settle();
        chk("beq_flush_ifid", {31'd0, flush_ifid}, 32'd1);
        chk("beq_flush_idex", {31'd0, flush_idex}, 32'd1);
        tick(); idle(); settle();
        chk("beq_target", pc, 32'h30);
        chk("beq_redir_noflush", {30'd0, flush_ifid, flush_idex}, 32'd0);
        tick(); settle(); chk("beq_after", pc, 32'h34);

        // 3: jalr beats beq, bit0 cleared; REDIRECT ignores EX flags
        ex_valid = 1; jalr = 1; beq = 1; ex_pc = 32'h40; ex_rs1 = 32'h1001; ex_imm = 32'h4; settle();
        chk("jalr_flush", {31'd0, flush_ifid}, 32'd1);
        tick(); idle();
        ex_valid = 1; jal = 1; ex_pc = 32'h200; ex_imm = 32'h100; settle();
        chk("jalr_target", pc, 32'h1004);
        chk("redir_ignores_ex", {30'd0, flush_ifid, flush_idex}, 32'd0);
        chk("redir_fetch_en", {31'd0, fetch_en}, 32'd1);
        tick(); idle(); settle();
        chk("redir_ignored_pc", pc, 32'h1008);

        // 4: stall holds, redirect beats stall
        ex_valid = 1; jal = 1; ex_pc = 32'h10; ex_imm = 32'h10; settle();
        tick(); idle(); stall = 1; settle();
        chk("jal_target", pc, 32'h20);
        tick(); settle(); chk("stall_hold1", pc, 32'h20);
        tick(); settle(); chk("stall_hold2", pc, 32'h20);
        tick(); settle(); chk("stall_hold3", pc, 32'h20);
        ex_valid = 1; bne = 1; ex_pc = 32'h70; ex_imm = 32'h10; settle();
        chk("bne_stall_flush", {31'd0, flush_idex}, 32'd1);
        tick(); idle(); stall = 0; settle();
        chk("bne_beats_stall", pc, 32'h80);
        tick(); settle(); chk("bne_after", pc, 32'h84);

        // 5: misaligned jal target
        ex_valid = 1; jal = 1; ex_pc = 32'h10; ex_imm = 32'h6; settle();
        chk("mis_pulse", {31'd0, misalign}, 32'd1);
        chk("mis_noflush", {30'd0, flush_ifid, flush_idex}, 32'd0);
        tick(); idle(); settle();
        chk("mis_pc_adv", pc, 32'h88);
        chk("mis_low_after", {31'd0, misalign}, 32'd0);

        // 6: reset during REDIRECT, then flags ignored in BOOT
        ex_valid = 1; bge = 1; ex_pc = 32'h100; ex_imm = 32'h20; settle();
        tick(); idle(); settle();
        chk("bge_target", pc, 32'h120);
        reset = 1;
        tick(); reset = 0; ex_valid = 1; blt = 1; ex_pc = 32'h0; ex_imm = 32'h40; settle();
        chk("rst_redir_pc", pc, 32'h0);
        chk("rst_redir_fetch", {31'd0, fetch_en}, 32'd0);
        chk("boot_ignores_ex", {30'd0, flush_ifid, flush_idex}, 32'd0);
        tick(); idle(); settle(); chk("rst_run_pc0", pc, 32'h0);
        tick(); settle(); chk("rst_run_pc4", pc, 32'h4);

        // PC wrap and jalr target carry drop
        ex_valid = 1; jal = 1; ex_pc = 32'hFFFF_FFF0; ex_imm = 32'hC; settle();
        tick(); idle(); settle();
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4, 32'h0);
        tick(); settle(); chk("wrap_next", pc, 32'h0);
        ex_valid = 1; jalr = 1; ex_rs1 = 32'hFFFF_FFF0; ex_imm = 32'h21; settle();
        chk("jalr_carry_flush", {31'd0, flush_ifid}, 32'd1);
        tick(); idle(); settle();
        chk("jalr_carry_pc", pc, 32'h10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
